dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Single-clock data-memory target for the core's load/store port. It is the responder end of the dmem_addr/dmem_wdata/dmem_we/dmem_rdata interface.
- Handles byte, halfword and word accesses using the funct3 size sideband. Store data arrives right-aligned; load data is returned right-aligned and zero-filled, and the core sign-extends.
- Holds a small posted-store buffer with store-to-load forwarding, so the memory array never stalls the core.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
SB_DEPTH, 2, posted-store buffer entries (>=1)

Ports:
clk  in  1  clock
arst  in  1  asynchronous active-high reset
dmem_addr_i  in  32  byte address from core
dmem_wdata_i  in  32  store data, right-aligned
dmem_we_i  in  1  store request this cycle
dmem_re_i  in  1  load request this cycle
dmem_size_i  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (load zero-fill is identical for signed and unsigned)
dmem_rdata_o  out  32  load data, right-aligned, zero-filled, registered
misaligned_o  out  1  one-cycle pulse: the previous request was misaligned
sb_count_o  out  $clog2(SB_DEPTH+1)  occupied store-buffer entries

Behaviour:
- Reset: clock and reset are as stated in Ports (clk; arst asynchronous, active-high). On reset, dmem_rdata_o=0, misaligned_o=0, sb_count_o=0, and all buffer entries are invalidated. Pending stores are discarded. The array is not reset.
- Requests and indexing:
  - One request per cycle. If we and re are both high, treat it as a store.
  - Word index = addr[$clog2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so the address wraps.
- Alignment:
  - A halfword access needs addr[0]=0; a word access needs addr[1:0]=0.
  - A misaligned store is dropped.
  - A misaligned load returns 0.
  - Either case pulses misaligned_o in the following cycle.
- Store:
  - Byte mask = 0001 / 0011 / 1111 for b / h / w, shifted left by addr[1:0].
  - Data is shifted left by 8*addr[1:0].
  - The entry {index, mask, data} is enqueued at the buffer tail at the clock edge. The store never writes the array directly.
- Drain:
  - On a cycle with no request, the oldest entry writes its masked bytes into the array and is dequeued.
  - If the buffer is full and a store arrives, the oldest entry drains in that same cycle and the new store is enqueued. Count is unchanged and there is no stall.
  - A load cycle never drains; the buffer holds.
- Load, 1-cycle latency:
  - The array word is read at the request edge, then merged with every valid buffer entry whose index matches, oldest to youngest, per byte lane. The youngest entry wins.
  - A store enqueued in cycle N is visible to a load issued in cycle N+1.
  - The merged word is shifted right by 8*addr[1:0] and masked to the access size.
  - The result is registered to dmem_rdata_o at the edge after the request. It holds until the next load completes; stores and idle cycles do not change it.
- Array: single write port (drain only), one read per cycle. Read and drain never coincide.
- Reset mid-operation: buffered stores are lost and the array keeps only drained data.

Test Plan:
1. Forwarding: sw 0x0000002a @0x104; next cycle lw @0x104 -> rdata_o=0x0000002a one cycle later, sb_count_o=1.
2. Merge: sw 0x11223344 @0x200, two idle cycles (drained, sb_count_o=0), sb 0x80 @0x201, then lw @0x200 -> 0x11228044; lbu @0x201 -> 0x00000080.
3. Halfword: sh 0x8001 @0x302; lhu @0x302 -> 0x00008001; lw @0x300 -> 0x8001xxxx with the upper half 0x8001.
4. Full buffer under load traffic: with SB_DEPTH=2, sw A @0x10, sw B @0x14 -> sb_count_o=2. Continuous loads keep it at 2. sw C @0x18 -> drains A, count stays 2. A later lw @0x10 returns A from the array.
5. Misaligned: lh @0x301 -> misaligned_o=1 for one cycle, rdata_o=0. sw @0x102 -> pulse, no enqueue, and a later lw @0x100 is unchanged.
6. Reset: sw 0xDEADBEEF @0x40, assert arst with no drain cycle -> sb_count_o=0 and rdata_o=0. After release, lw @0x40 returns the pre-store array contents.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory target for the core load/store port. Stores are posted into a
//   small in-order buffer and written to the array only on idle cycles (or
//   when a new store finds the buffer full). Loads read the array and overlay
//   every matching buffered store, so the core always sees its latest data.
//
// Ports
//   clk, arst        clock, asynchronous active-high reset
//   dmem_addr_i      byte address; bits above the word index are ignored
//   dmem_wdata_i     store data, right-aligned
//   dmem_we_i        store request (wins when dmem_re_i is also high)
//   dmem_re_i        load request
//   dmem_size_i      funct3 size: b/h/w, bu/hu
//   dmem_rdata_o     registered load result, right-aligned, zero-filled
//   misaligned_o     pulses one cycle after a misaligned request
//   sb_count_o       occupied store-buffer entries

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = 2
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic [31:0]                       dmem_addr_i,
    input  logic [31:0]                       dmem_wdata_i,
    input  logic                              dmem_we_i,
    input  logic                              dmem_re_i,
    input  logic [2:0]                        dmem_size_i,
    output logic [31:0]                       dmem_rdata_o,
    output logic                              misaligned_o,
    output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       mask;
        logic [31:0]      data;
    } sb_ent_t;

    // Array: no reset, single write port fed only by the drain path.
    logic [31:0] mem_q [DEPTH_WORDS];

    sb_ent_t          sb_q [SB_DEPTH];
    sb_ent_t          sb_d [SB_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mis_q, mis_d;

    // Request decode
    logic             is_store, is_load, is_idle;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       size_mask;
    logic             misaligned;
    sb_ent_t          new_ent;
    logic             full, drain;

    assign is_store = dmem_we_i;
    assign is_load  = dmem_re_i & ~dmem_we_i;
    assign is_idle  = ~dmem_we_i & ~dmem_re_i;
    assign off      = dmem_addr_i[1:0];
    assign idx      = dmem_addr_i[IDX_W+1:2];

    // size[1] selects word, else size[0] selects halfword, else byte;
    // the signed/unsigned bit does not change anything here.
    assign size_mask  = dmem_size_i[1] ? 4'b1111 : (dmem_size_i[0] ? 4'b0011 : 4'b0001);
    assign misaligned = (dmem_size_i[1] & (off != 2'b00)) |
                        (~dmem_size_i[1] & dmem_size_i[0] & off[0]);

    assign new_ent.idx  = idx;
    assign new_ent.mask = size_mask << off;
    assign new_ent.data = dmem_wdata_i << {off, 3'b000};

    assign full = (cnt_q == CNT_W'(SB_DEPTH));

    logic unused_bits;
    assign unused_bits = ^{dmem_addr_i[31:IDX_W+2], dmem_size_i[2]};

    // Store buffer: entry 0 is the oldest. A drain pops entry 0 and shifts
    // the rest down; a full buffer drains and enqueues in the same cycle.
    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        drain = 1'b0;
        if (is_store && !misaligned) begin
            if (full) begin
                drain = 1'b1;
                for (int i = 0; i < SB_DEPTH - 1; i++) sb_d[i] = sb_q[i+1];
                sb_d[SB_DEPTH-1] = new_ent;
            end else begin
                for (int i = 0; i < SB_DEPTH; i++)
                    if (CNT_W'(i) == cnt_q) sb_d[i] = new_ent;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (is_idle && cnt_q != '0) begin
            drain = 1'b1;
            for (int i = 0; i < SB_DEPTH - 1; i++) sb_d[i] = sb_q[i+1];
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Load path: array word overlaid oldest-to-youngest with matching
    // buffered bytes, then aligned down and masked to the access size.
    logic [31:0] merged, shifted, lane_mask, ld_val;

    always_comb begin
        merged = mem_q[idx];
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CNT_W'(i) < cnt_q && sb_q[i].idx == idx) begin
                for (int b = 0; b < 4; b++)
                    if (sb_q[i].mask[b]) merged[8*b +: 8] = sb_q[i].data[8*b +: 8];
            end
        end
        shifted = merged >> {off, 3'b000};
        for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{size_mask[b]}};
        ld_val  = misaligned ? 32'h0 : (shifted & lane_mask);
        rdata_d = is_load ? ld_val : rdata_q;
        mis_d   = (dmem_we_i | dmem_re_i) & misaligned;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= sb_d[i];
        end
    end

    // Drain write. Gated by reset so a pending store never lands while the
    // buffer is being discarded.
    always_ff @(posedge clk) begin
        if (drain && !arst) begin
            for (int b = 0; b < 4; b++)
                if (sb_q[0].mask[b]) mem_q[sb_q[0].idx][8*b +: 8] <= sb_q[0].data[8*b +: 8];
        end
    end

    assign dmem_rdata_o = rdata_q;
    assign misaligned_o = mis_q;
    assign sb_count_o   = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a memory-level reference model:
// committed memory plus an ordered list of not-yet-committed stores.

module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int SBD   = 2;
    localparam int CW    = $clog2(SBD + 1);

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic          we = 1'b0, re = 1'b0;
    logic [2:0]    size = '0;
    logic [31:0]   rdata;
    logic          mis;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .SB_DEPTH(SBD)) dut (
        .clk(clk), .arst(arst),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_we_i(we), .dmem_re_i(re), .dmem_size_i(size),
        .dmem_rdata_o(rdata), .misaligned_o(mis), .sb_count_o(cnt)
    );

    typedef struct {
        int          idx;
        logic [3:0]  mask;
        logic [31:0] data;
    } ent_t;

    logic [31:0] mm [DEPTH];
    ent_t        pq [$];
    logic [31:0] exp_rdata = '0;
    logic        exp_mis = 1'b0;
    int          exp_cnt = 0;
    bit          chk_en = 0;
    int          n_vec = 0, n_bad = 0;
    logic [2:0]  sz_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata", rdata, exp_rdata);
            check("misaligned", {31'b0, mis}, {31'b0, exp_mis});
            check("sb_count", 32'(cnt), 32'(exp_cnt));
        end
    end

    function automatic logic [31:0] init_val(int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    function automatic void commit_front();
        ent_t e = pq.pop_front();
        for (int b = 0; b < 4; b++)
            if (e.mask[b]) mm[e.idx][8*b +: 8] = e.data[8*b +: 8];
    endfunction

    // Latest value of a word as the core should see it.
    function automatic logic [31:0] view(int idx);
        logic [31:0] w = mm[idx];
        foreach (pq[k])
            if (pq[k].idx == idx)
                for (int b = 0; b < 4; b++)
                    if (pq[k].mask[b]) w[8*b +: 8] = pq[k].data[8*b +: 8];
        return w;
    endfunction

    // Drive one request for the next rising edge and advance the model.
    task automatic op(bit w, bit r, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        int          o, ix, nbytes;
        bit          bad;
        logic [3:0]  m;
        logic [31:0] v;
        ent_t        e;
        @(negedge clk);
        #1;
        we = w; re = r; addr = a; size = sz; wdata = wd;
        o      = int'(a[1:0]);
        ix     = int'((a >> 2) % DEPTH);
        nbytes = sz[1] ? 4 : (sz[0] ? 2 : 1);
        bad    = (o % nbytes) != 0;
        if (w) begin
            if (!bad) begin
                m = '0;
                for (int k = 0; k < nbytes; k++) m[o+k] = 1'b1;
                e.idx = ix; e.mask = m; e.data = wd << (8 * o);
                pq.push_back(e);
                if (pq.size() > SBD) commit_front();
            end
        end else if (r) begin
            if (bad) exp_rdata = 32'h0;
            else begin
                v = view(ix) >> (8 * o);
                exp_rdata = (nbytes == 4) ? v : (nbytes == 2) ? (v & 32'hFFFF) : (v & 32'hFF);
            end
        end else if (pq.size() > 0) begin
            commit_front();
        end
        exp_mis = (w || r) && bad;
        exp_cnt = pq.size();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) op(0, 0, 32'h0, 3'b010, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        we = 0; re = 0;
        arst = 1'b1;
        pq.delete();
        exp_rdata = '0; exp_mis = 1'b0; exp_cnt = 0;
        @(negedge clk);
        #1;
        arst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 arst = 1'b1;
        chk_en = 1;
        @(negedge clk);
        #1 arst = 1'b0;

        // Give every word a known value so later loads are fully predictable.
        for (int i = 0; i < DEPTH; i++) op(1, 0, 32'(i * 4), 3'b010, init_val(i));
        idle(3);

        // Forwarding
        op(1, 0, 32'h104, 3'b010, 32'h0000002a);
        op(0, 1, 32'h104, 3'b010, 32'h0);
        settle();
        check("fwd_rdata", rdata, 32'h0000002a);
        check("fwd_model", exp_rdata, 32'h0000002a);
        check("fwd_count", 32'(cnt), 32'd1);

        // Merge
        idle(2);
        op(1, 0, 32'h200, 3'b010, 32'h11223344);
        idle(2);
        settle();
        check("merge_drained", 32'(cnt), 32'd0);
        op(1, 0, 32'h201, 3'b000, 32'hFFFFFF80);
        op(0, 1, 32'h200, 3'b010, 32'h0);
        settle();
        check("merge_lw", rdata, 32'h11228044);
        check("merge_model", exp_rdata, 32'h11228044);
        op(0, 1, 32'h201, 3'b100, 32'h0);
        settle();
        check("merge_lbu", rdata, 32'h00000080);

        // Halfword
        idle(2);
        op(1, 0, 32'h302, 3'b001, 32'h00008001);
        op(0, 1, 32'h302, 3'b101, 32'h0);
        settle();
        check("half_lhu", rdata, 32'h00008001);
        op(0, 1, 32'h300, 3'b010, 32'h0);
        settle();
        check("half_lw", rdata, 32'h800100C0);

        // Full buffer under load traffic
        idle(2);
        op(1, 0, 32'h10, 3'b010, 32'hAAAA0001);
        op(1, 0, 32'h14, 3'b010, 32'hBBBB0002);
        settle();
        check("full_count", 32'(cnt), 32'd2);
        for (int i = 0; i < 3; i++) op(0, 1, 32'h20, 3'b010, 32'h0);
        settle();
        check("full_hold", 32'(cnt), 32'd2);
        op(1, 0, 32'h18, 3'b010, 32'hCCCC0003);
        settle();
        check("full_push", 32'(cnt), 32'd2);
        op(0, 1, 32'h10, 3'b010, 32'h0);
        settle();
        check("full_drained_a", rdata, 32'hAAAA0001);

        // Misaligned
        op(0, 1, 32'h301, 3'b001, 32'h0);
        settle();
        check("mis_ld_pulse", {31'b0, mis}, 32'd1);
        check("mis_ld_zero", rdata, 32'h0);
        idle(1);
        settle();
        check("mis_ld_end", {31'b0, mis}, 32'd0);
        op(1, 0, 32'h102, 3'b010, 32'h12345678);
        settle();
        check("mis_st_pulse", {31'b0, mis}, 32'd1);
        check("mis_st_noenq", 32'(cnt), 32'd1);
        op(0, 1, 32'h100, 3'b010, 32'h0);
        settle();
        check("mis_st_unchanged", rdata, 32'hC0DE0040);

        // Reset discards a pending store
        idle(3);
        op(1, 0, 32'h40, 3'b010, 32'hDEADBEEF);
        do_reset();
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        op(0, 1, 32'h40, 3'b010, 32'h0);
        settle();
        check("rst_lost_store", rdata, 32'hC0DE0010);

        // Random traffic in a small index window, upper address bits random
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            a = $urandom & 32'hFFFFF03F;
            if ($urandom_range(0, 599) == 0) do_reset();
            else if (r < 35) op(1, 0, a, sz_tab[$urandom_range(0, 4)], $urandom);
            else if (r < 75) op(0, 1, a, sz_tab[$urandom_range(0, 4)], $urandom);
            else if (r < 80) op(1, 1, a, sz_tab[$urandom_range(0, 4)], $urandom);
            else idle(1);
        end
        settle();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
